// File: rtl/rs232_tx_sched.sv
// rs232_tx_sched: round-robin scheduler sharing one rs232 byte transmitter among N_REQ requesters
module rs232_tx_sched #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int GAP_CYC  = 16,
  parameter int HOLD_TMO = 100000
) (
  input  logic                    clk_ref,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        i_req_vld,
  input  logic [N_REQ*DATA_W-1:0] i_req_dat,
  input  logic [N_REQ-1:0]        i_req_last,
  output logic [N_REQ-1:0]        o_req_rdy,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_tx_start,
  output logic [DATA_W-1:0]       o_tx_dat,
  input  logic                    i_tx_busy,
  input  logic                    i_tx_done,
  output logic                    o_busy,
  output logic                    o_abort
);
  localparam int IW = $clog2(N_REQ);
  localparam int GW = GAP_CYC > 0 ? $clog2(GAP_CYC + 1) : 1;
  localparam int HW = HOLD_TMO > 0 ? $clog2(HOLD_TMO + 1) : 1;
  localparam logic [GW-1:0] GAP_END = GW'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
  localparam logic [HW-1:0] HOLD_END = HW'(HOLD_TMO > 0 ? HOLD_TMO - 1 : 0);

  typedef enum logic [1:0] {IDLE, XFER, WAIT, GAP} state_t;

  state_t          state;
  logic [IW-1:0]   ptr, g, sel, ptr_nxt;
  logic [GW-1:0]   gap_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            last_r, hs, tmo, fin;

  assign hs        = state == XFER && i_req_vld[g] && !i_tx_busy;
  assign tmo       = HOLD_TMO > 0 && state == XFER && !hs && hold_cnt == HOLD_END;
  assign fin       = tmo || (state == WAIT && i_tx_done && last_r);
  assign ptr_nxt   = (g == IW'(N_REQ - 1)) ? '0 : g + 1'b1;
  assign o_req_rdy = o_grant & {N_REQ{hs}};
  assign o_busy    = state != IDLE;

  // first valid requester at or above the pointer, wrapping; lowest offset wins
  always_comb begin
    sel = ptr;
    for (int i = N_REQ - 1; i >= 0; i--)
      sel = i_req_vld[(int'(ptr) + i) % N_REQ] ? IW'((int'(ptr) + i) % N_REQ) : sel;
  end

  // arbitration, byte launch, frame wait and inter-packet gap; packet end or timeout releases the grant
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      g          <= '0;
      o_grant    <= '0;
      o_tx_start <= 1'b0;
      o_tx_dat   <= '0;
      o_abort    <= 1'b0;
      last_r     <= 1'b0;
      gap_cnt    <= '0;
      hold_cnt   <= '0;
    end else begin
      o_tx_start <= 1'b0;
      o_abort    <= tmo;
      if (fin) begin
        o_grant <= '0;
        ptr     <= ptr_nxt;
        gap_cnt <= '0;
        state   <= GAP_CYC > 0 ? GAP : IDLE;
      end else begin
        case (state)
          IDLE: if (|i_req_vld) begin
            g        <= sel;
            o_grant  <= N_REQ'(1) << sel;
            hold_cnt <= '0;
            state    <= XFER;
          end
          XFER: if (hs) begin
            o_tx_dat   <= i_req_dat[g*DATA_W +: DATA_W];
            last_r     <= i_req_last[g];
            o_tx_start <= 1'b1;
            state      <= WAIT;
          end else begin
            hold_cnt <= &hold_cnt ? hold_cnt : hold_cnt + 1'b1;
          end
          WAIT: if (i_tx_done) begin
            hold_cnt <= '0;
            state    <= XFER;
          end
          GAP: begin
            gap_cnt <= &gap_cnt ? gap_cnt : gap_cnt + 1'b1;
            if (gap_cnt == GAP_END) state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/rs232_tx_sched.md
Name: rs232_tx_sched

Overview:
- Round-robin scheduler that shares one rs232 byte transmitter between N_REQ requesters.
- Each requester supplies bytes over a valid/ready handshake and marks its final byte with a last flag.
- A granted requester keeps the transmitter until it sends its last byte or stalls past a timeout.
- Sits between the application byte sources and the rs232 transmit datapath, which is sequenced by the existing rs232_ctrl baud engine.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
GAP_CYC, 16, idle clk_ref cycles inserted after each packet; 0 = no gap
HOLD_TMO, 100000, clk_ref cycles a granted requester may hold without valid before abort; 0 = never abort

Ports:
clk_ref  input  1  reference clock
rst_n  input  1  asynchronous active-low reset
i_req_vld  input  N_REQ  per-requester byte valid
i_req_dat  input  N_REQ*DATA_W  per-requester byte; requester k uses bits [k*DATA_W +: DATA_W]
i_req_last  input  N_REQ  byte is the final byte of its packet; sampled with i_req_vld
o_req_rdy  output  N_REQ  byte accepted this cycle (combinational)
o_grant  output  N_REQ  one-hot registered grant; all-zero when idle
o_tx_start  output  1  one-cycle pulse that launches a transmitter frame
o_tx_dat  output  DATA_W  byte to send; stable from o_tx_start until i_tx_done
i_tx_busy  input  1  transmitter frame in progress
i_tx_done  input  1  one-cycle pulse at end of stop bit
o_busy  output  1  high in every state except IDLE
o_abort  output  1  one-cycle pulse when a grant is revoked by HOLD_TMO

Behaviour:
- Reset:
  - state = IDLE, round-robin pointer = 0.
  - o_grant, o_tx_start, o_tx_dat, o_busy and o_abort are all 0.
  - Reset takes effect immediately, including mid-packet; no partial frame is retried after reset.
- IDLE:
  - If any i_req_vld is set, select the first set index searching upward from the pointer, wrapping at N_REQ.
  - Register the one-hot o_grant, then enter XFER on the next cycle.
  - Arbitration latency from vld to grant is 1 cycle.
- XFER (granted index g):
  - o_req_rdy[g] = i_req_vld[g] && !i_tx_busy. All other rdy bits are always 0.
  - On handshake, capture the byte into o_tx_dat and the last flag into last_r.
  - Next cycle: o_tx_start = 1 for exactly 1 cycle, then enter WAIT.
  - The hold counter counts cycles in XFER without a handshake and clears on each handshake.
  - When the counter reaches HOLD_TMO (HOLD_TMO > 0): pulse o_abort, clear o_grant, enter GAP.
- WAIT:
  - On i_tx_done: if last_r, enter GAP; otherwise return to XFER.
  - i_tx_busy is ignored in WAIT; a missing i_tx_done keeps the block in WAIT indefinitely.
- GAP:
  - Set pointer = (g+1) mod N_REQ. Set o_grant = 0 on entry.
  - Count GAP_CYC cycles, then enter IDLE.
  - When GAP_CYC = 0, go from WAIT/abort directly to IDLE, with the pointer still updated.
- Non-grant behaviour:
  - Requesters other than g are never granted mid-packet; their vld is held off by rdy = 0.
  - New requests raised during GAP are arbitrated only in IDLE.
- Edge cases:
  - Simultaneous vld on all inputs: strict rotation g, g+1, ... across successive packets.
  - A single requester asserting continuously is re-granted after each gap.
- Widths:
  - Pointer and index are clog2(N_REQ) bits.
  - Gap counter is clog2(GAP_CYC+1) bits; hold counter is clog2(HOLD_TMO+1) bits.
  - Counters saturate and never wrap.
- o_busy = (state != IDLE).

Test Plan:
- Reset then a single packet: requester 1 sends bytes 0x55, 0xA3 (last). Required: o_grant = 4'b0010 one cycle after vld; two o_tx_start pulses carrying 0x55 then 0xA3; rdy[1] asserted once per byte; o_grant returns to 0 at GAP entry; o_busy falls GAP_CYC cycles after the second i_tx_done.
- All four requesters hold 1-byte packets continuously from reset. Required: grant order 0,1,2,3,0,1; no byte from a non-granted requester appears on o_tx_dat.
- Requester 2 sends 0x10 (not last), then drops vld. Required: with HOLD_TMO = 50, o_abort pulses exactly 50 cycles after entering XFER; grant clears; the next IDLE arbitration starts at index 3.
- Transmitter busy: hold i_tx_busy = 1 while requester 0 is valid in XFER. Required: rdy[0] = 0 and no o_tx_start until busy falls; then a single handshake and start.
- Reset mid-packet: assert rst_n = 0 during WAIT. Required: all outputs 0 immediately; after release, the first grant goes to the lowest valid index (pointer = 0).
- GAP_CYC = 0 configuration: back-to-back 1-byte packets from requesters 0 and 1. Required: the IDLE-to-grant cycle directly follows i_tx_done + 1, with no gap cycles.
